serial_mac_lanes: RTL and testbench
===================================

Name: serial_mac_lanes

Overview:
- Multi-lane bit-serial multiply-accumulate engine: NUM_LANES independent lanes share one controller.
- Each lane computes a running dot product sum(a*b) over a sequence of operand sets.
- Multiplier bits are consumed LSB-first by an internal shift-add datapath; there is no submodule dependency.
- Signed/unsigned mode, guard-bit accumulators and valid/ready handshakes on both sides. Successor to the single-lane sequential MAC for vector datapaths.

Parameters:
- A_WIDTH, 16: multiplicand width per lane.
- B_WIDTH, 16: multiplier width per lane; equals multiply cycles per operand set (>=2).
- NUM_LANES, 4: number of parallel lanes (>=1).
- GUARD_BITS, 8: extra accumulator MSBs; ACC_WIDTH = A_WIDTH+B_WIDTH+GUARD_BITS (derived localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear_acc  in  1  zero all accumulators; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands; latched on accept.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- in_last  in  1  final operand set of the current dot product.
- a_in  in  NUM_LANES*A_WIDTH  multiplicands; lane k at [k*A_WIDTH +: A_WIDTH].
- b_in  in  NUM_LANES*B_WIDTH  multipliers; lane k at [k*B_WIDTH +: B_WIDTH].
- out_valid  out  1  acc_out holds a completed dot product.
- out_ready  in  1  consumer takes the result.
- acc_out  out  NUM_LANES*ACC_WIDTH  per-lane accumulator values.
- overflow  out  NUM_LANES  sticky per-lane overflow flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All accumulators, product registers, bit counter and latched operands are cleared to 0.
  - in_ready=0 while rst_n is low; out_valid=0; acc_out=0; overflow=0.
- Reset mid-operation aborts the operation with no partial update retained.
- States: IDLE, MUL, ACC, OUT.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid&&in_ready at a rising edge. On accept: latch a_in, b_in, signed_mode and in_last; clear products; counter=0; go to MUL.
  - If clear_acc=1 in the same cycle, accumulators and overflow flags are zeroed and the accepted set accumulates from zero.
  - clear_acc is ignored in MUL, ACC and OUT.
- MUL: exactly B_WIDTH cycles. Step i:
  - product += (b[i] ? ext(a)<<i : 0), where ext is sign-extension if signed else zero-extension, to A_WIDTH+B_WIDTH bits.
  - At i=B_WIDTH-1 with signed mode, the term is subtracted instead of added.
  - After step B_WIDTH-1, go to ACC.
- ACC: one cycle.
  - Each lane: acc <= acc + ext(product) to ACC_WIDTH, extended per latched mode.
  - Overflow is detected on ACC_WIDTH+1-bit intermediate: signed = sign mismatch; unsigned = carry-out.
  - If latched last=1, go to OUT; otherwise go to IDLE.
- OUT:
  - out_valid=1; acc_out stable.
  - On out_ready: accumulators and overflow clear, out_valid drops, go to IDLE.
- Latency:
  - accept edge to in_ready reassert (non-last) = B_WIDTH+2 cycles.
  - accept edge to out_valid (last) = B_WIDTH+2 cycles.
- acc_out is always the live accumulator register.
- Overflow flags are sticky until clear_acc or the output handshake.
- in_ready=0 in MUL, ACC and OUT; no operand buffering.

Optional Feature:
- Macro SERIAL_MAC_SAT_EN.
- Defined: on overflow the accumulator saturates to its bound and the overflow flag sets.
  - Signed bounds: +2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1).
  - Unsigned bound: 2^ACC_WIDTH-1.
  - Saturated values remain saturated while further same-direction overflows occur.
- Undefined: accumulators wrap modulo 2^ACC_WIDTH; the overflow flag still sets, for debug.

Test Plan:
- Unsigned, lane0 a=3 b=5 last=1 -> out_valid exactly 18 cycles after accept, lane0 acc=15, other lanes 0, overflow=0.
- Signed dot product, lane1 {(-4)*7, 6*(-3), (-2)*(-9)} with last on third -> lane1 acc=-28 (0xFFFF_FFFF_E4 in 40 bits), held until out_ready; after handshake acc=0.
- Extremes, signed a=-32768 b=-32768 -> product +2^30; unsigned a=b=0xFFFF -> 0xFFFE0001.
- clear_acc asserted together with accept after a prior non-last set accumulated 100 -> result equals the new product only; clear_acc pulsed during MUL -> no effect.
- GUARD_BITS=0, unsigned: 0xFFFF*0xFFFF accumulated twice -> with SERIAL_MAC_SAT_EN acc=0xFFFFFFFF and overflow=1; without it acc=0xFFFC0002 and overflow=1.
- rst_n dropped mid-MUL and out_valid held with out_ready=0 for 5 cycles -> immediate IDLE with all outputs 0; for the held case, acc_out stable and in_ready=0 throughout.

Source files
------------

// File: rtl/serial_mac_lanes.sv
// serial_mac_lanes: multi-lane bit-serial multiply-accumulate engine with shared controller
// Ports: clk, rst_n (async active-low); clear_acc, signed_mode; in_valid/in_ready/in_last with
// a_in/b_in lane-packed operands; out_valid/out_ready with acc_out lane-packed accumulators and
// sticky per-lane overflow. Define SERIAL_MAC_SAT_EN to saturate accumulators on overflow
// instead of wrapping.
module serial_mac_lanes #(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 16,
  parameter int NUM_LANES  = 4,
  parameter int GUARD_BITS = 8,
  localparam int ACC_WIDTH = A_WIDTH + B_WIDTH + GUARD_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear_acc,
  input  logic                           signed_mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [NUM_LANES*A_WIDTH-1:0]   a_in,
  input  logic [NUM_LANES*B_WIDTH-1:0]   b_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*ACC_WIDTH-1:0] acc_out,
  output logic [NUM_LANES-1:0]           overflow
);
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int CW = (B_WIDTH > 2) ? $clog2(B_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic sgn, last, in_ready_nx, out_valid_nx;
  logic accept, take, last_step;
  assign accept = in_valid && in_ready;
  assign take = out_valid && out_ready;
  assign last_step = cnt == CW'(B_WIDTH - 1);
  // in_ready/out_valid are registered from the current state, which places them one cycle
  // after the state change and gives the B_WIDTH+2 accept-to-response latency
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nx;
      in_ready <= in_ready_nx;
      out_valid <= out_valid_nx;
    end
  always_comb
    state_nx = (state == IDLE) ? (accept ? MUL : IDLE) :
               (state == MUL)  ? (last_step ? ACC : MUL) :
               (state == ACC)  ? (last ? OUT : IDLE) :
                                 (take ? IDLE : OUT);
  always_comb begin
    in_ready_nx = state == IDLE && !accept;
    out_valid_nx = state == OUT && !take;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sgn <= 1'b0;
      last <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      sgn <= signed_mode;
      last <= in_last;
    end else if (state == MUL) begin
      cnt <= cnt + 1'b1;
    end
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [A_WIDTH-1:0] a_l;
    logic [P_WIDTH-1:0] a_r, prod, term;
    logic [B_WIDTH-1:0] b_r;
    logic [ACC_WIDTH-1:0] acc, nv;
    logic [ACC_WIDTH:0] sum;
    logic ov, ovf;
    assign a_l = a_in[k*A_WIDTH +: A_WIDTH];
    // a_r holds ext(a)<<i and b_r[0] is multiplier bit i during MUL step i
    assign term = b_r[0] ? a_r : '0;
    assign sum = {sgn & acc[ACC_WIDTH-1], acc} + {{(GUARD_BITS+1){sgn & prod[P_WIDTH-1]}}, prod};
    assign ovf = sgn ? sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1] : sum[ACC_WIDTH];
`ifdef SERIAL_MAC_SAT_EN
    // the ACC_WIDTH+1 bit sum carries the true sign, selecting the bound to clamp to
    assign nv = !ovf ? sum[ACC_WIDTH-1:0] :
                sgn ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}} : '1;
`else
    assign nv = sum[ACC_WIDTH-1:0];
`endif
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        a_r <= '0;
        b_r <= '0;
        prod <= '0;
        acc <= '0;
        ov <= 1'b0;
      end else begin
        if (accept) begin
          a_r <= {{B_WIDTH{signed_mode & a_l[A_WIDTH-1]}}, a_l};
          b_r <= b_in[k*B_WIDTH +: B_WIDTH];
          prod <= '0;
        end else if (state == MUL) begin
          a_r <= a_r << 1;
          b_r <= b_r >> 1;
          // the multiplier MSB carries negative weight in two's complement
          prod <= (sgn && last_step) ? prod - term : prod + term;
        end
        if ((state == IDLE && clear_acc) || take) begin
          acc <= '0;
          ov <= 1'b0;
        end else if (state == ACC) begin
          acc <= nv;
          ov <= ov | ovf;
        end
      end
    assign acc_out[k*ACC_WIDTH +: ACC_WIDTH] = acc;
    assign overflow[k] = ov;
  end
endmodule

// File: tb/tb_serial_mac_lanes.sv
// tb_serial_mac_lanes: scoreboard bench for serial_mac_lanes, default lanes plus a GUARD_BITS=0 copy
module tb_serial_mac_lanes;
  localparam int A = 16, B = 16, N = 4, G = 8, AW = 40, N1 = 2, AW1 = 32;
  logic clk = 0, rst_n = 0, clear_acc = 0, signed_mode = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [N*A-1:0] a_in = '0;
  logic [N*B-1:0] b_in = '0;
  logic in_ready, out_valid, in_ready1, out_valid1;
  logic [N*AW-1:0] acc_out;
  logic [N-1:0] overflow;
  logic [N1*AW1-1:0] acc_out1;
  logic [N1-1:0] overflow1;
  always #5 clk = ~clk;
  serial_mac_lanes #(.A_WIDTH(A), .B_WIDTH(B), .NUM_LANES(N), .GUARD_BITS(G)) dut (
    .clk(clk), .rst_n(rst_n), .clear_acc(clear_acc), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .overflow(overflow));
  serial_mac_lanes #(.A_WIDTH(A), .B_WIDTH(B), .NUM_LANES(N1), .GUARD_BITS(0)) dut0g (
    .clk(clk), .rst_n(rst_n), .clear_acc(clear_acc), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready1), .in_last(in_last), .a_in(a_in[N1*A-1:0]),
    .b_in(b_in[N1*B-1:0]), .out_valid(out_valid1), .out_ready(out_ready), .acc_out(acc_out1),
    .overflow(overflow1));
  typedef struct {
    logic [N*AW-1:0] e0;
    logic [N-1:0] o0;
    logic [N1*AW1-1:0] e1;
    logic [N1-1:0] o1;
  } exp_t;
  exp_t q[$];
  logic [63:0] m0[N];
  bit v0[N];
  logic [63:0] m1[N1];
  bit v1[N1];
  int checks = 0, errors = 0;
  bit hold = 1;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask
  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask
  // exact-integer dot-product step: add the true product, then wrap or clamp to aw bits
  function automatic void upd(input int aw, input bit sg, input longint p, input logic [63:0] ai,
                              input bit oi, output logic [63:0] ao, output bit oo);
    longint mask = (longint'(1) << aw) - 1;
    longint v, s, mx, mn;
    bit o;
    if (sg) begin
      v = longint'(ai << (64 - aw)) >>> (64 - aw);
      mx = (longint'(1) << (aw - 1)) - 1;
      mn = -mx - 1;
      s = v + p;
      o = s > mx || s < mn;
`ifdef SERIAL_MAC_SAT_EN
      if (o) s = (s > mx) ? mx : mn;
`endif
    end else begin
      v = longint'(ai);
      s = v + p;
      o = s > mask;
`ifdef SERIAL_MAC_SAT_EN
      if (o) s = mask;
`endif
    end
    ao = 64'(s) & 64'(mask);
    oo = oi | o;
  endfunction
  function automatic longint prd(input int k, input bit sg);
    logic [A-1:0] a;
    logic [B-1:0] b;
    a = a_in[k*A +: A];
    b = b_in[k*B +: B];
    return sg ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
  endfunction
  task automatic model_zero();
    for (int k = 0; k < N; k++) begin m0[k] = 0; v0[k] = 0; end
    for (int k = 0; k < N1; k++) begin m1[k] = 0; v1[k] = 0; end
  endtask
  task automatic model(input bit sg, input bit clr, input bit last);
    exp_t e;
    if (clr) model_zero();
    for (int k = 0; k < N; k++) upd(AW, sg, prd(k, sg), m0[k], v0[k], m0[k], v0[k]);
    for (int k = 0; k < N1; k++) upd(AW1, sg, prd(k, sg), m1[k], v1[k], m1[k], v1[k]);
    if (last) begin
      for (int k = 0; k < N; k++) begin e.e0[k*AW +: AW] = m0[k][AW-1:0]; e.o0[k] = v0[k]; end
      for (int k = 0; k < N1; k++) begin e.e1[k*AW1 +: AW1] = m1[k][AW1-1:0]; e.o1[k] = v1[k]; end
      q.push_back(e);
      model_zero();
    end
  endtask
  task automatic send(input logic [N*A-1:0] a, input logic [N*B-1:0] b, input bit sg,
                      input bit last, input bit clr, input bit pulse, input bit abort);
    int n = 0;
    int lat = 0;
    @(negedge clk);
    a_in = a; b_in = b; signed_mode = sg; in_last = last; clear_acc = clr; in_valid = 1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      fail("accept");
      in_valid = 0; clear_acc = 0;
      return;
    end
    model(sg, clr, last);
    @(posedge clk);
    #1 in_valid = 0; clear_acc = 0;
    if (abort) begin
      repeat (5) @(posedge clk);
      #1 rst_n = 0;
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_acc", acc_out, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_acc_g0", acc_out1, 0);
      model_zero();
      @(negedge clk) rst_n = 1;
      return;
    end
    while (!(last ? out_valid : in_ready) && lat < 40) begin
      @(posedge clk);
      #1 lat++;
      clear_acc = pulse && lat >= 1 && lat <= 6;
    end
    clear_acc = 0;
    chk(last ? "lat_out" : "lat_ready", lat, B + 2);
  endtask
  task automatic drain();
    int n = 0;
    hold = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) fail("drain");
  endtask
  initial forever begin
    @(posedge clk);
    #2 out_ready = hold ? 1'b0 : ($urandom_range(0, 2) == 0);
  end
  initial begin
    logic [N*AW-1:0] pa;
    bit pv = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) pv = 0;
      else begin
        chk("valid_g0", out_valid1, out_valid);
        if (out_valid) begin
          chk("ready_in_out", in_ready, 0);
          if (pv) chk("acc_stable", acc_out, pa);
          pa = acc_out;
          pv = 1;
          if (out_ready) begin
            pv = 0;
            if (q.size() == 0) fail("unexpected_out");
            else begin
              e = q.pop_front();
              chk("acc", acc_out, e.e0);
              chk("ovf", overflow, e.o0);
              chk("acc_g0", acc_out1, e.e1);
              chk("ovf_g0", overflow1, e.o1);
            end
          end
        end else pv = 0;
      end
    end
  end
  initial begin
    logic [N*A-1:0] av;
    logic [N*B-1:0] bv;
    model_zero();
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_acc", acc_out, 0);
    chk("reset_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    hold = 1;
    av = '0; bv = '0; av[15:0] = 3; bv[15:0] = 5;
    send(av, bv, 0, 1, 0, 0, 0);
    chk("t1_acc", acc_out, 160'd15);
    chk("t1_ovf", overflow, 0);
    drain();
    hold = 1;
    av = '0; bv = '0; av[31:16] = 16'hFFFC; bv[31:16] = 16'd7;
    send(av, bv, 1, 0, 0, 0, 0);
    av[31:16] = 16'd6; bv[31:16] = 16'hFFFD;
    send(av, bv, 1, 0, 0, 0, 0);
    av[31:16] = 16'hFFFE; bv[31:16] = 16'hFFF7;
    send(av, bv, 1, 1, 0, 0, 0);
    chk("t2_lane1", acc_out[79:40], 40'hFFFFFFFFE4);
    drain();
    @(negedge clk);
    chk("t2_cleared", acc_out, 0);
    av = '0; bv = '0; av[47:32] = 16'h8000; bv[47:32] = 16'h8000;
    send(av, bv, 1, 1, 0, 0, 0);
    chk("t3_signed_ext", acc_out[119:80], 40'h0040000000);
    drain();
    av = '0; bv = '0; av[63:48] = 16'hFFFF; bv[63:48] = 16'hFFFF;
    send(av, bv, 0, 1, 0, 0, 0);
    chk("t3_unsigned_ext", acc_out[159:120], 40'h00FFFE0001);
    drain();
    av = '0; bv = '0; av[15:0] = 10; bv[15:0] = 10;
    send(av, bv, 0, 0, 0, 0, 0);
    chk("t4_acc100", acc_out[39:0], 40'd100);
    av[15:0] = 7; bv[15:0] = 9;
    send(av, bv, 0, 1, 1, 0, 0);
    chk("t4_clear", acc_out[39:0], 40'd63);
    drain();
    av[15:0] = 5; bv[15:0] = 5;
    send(av, bv, 0, 0, 0, 1, 0);
    av[15:0] = 2; bv[15:0] = 3;
    send(av, bv, 0, 1, 0, 0, 0);
    chk("t4_pulse_ignored", acc_out[39:0], 40'd31);
    drain();
    av = '0; bv = '0; av[31:0] = 32'hFFFFFFFF; bv[31:0] = 32'hFFFFFFFF;
    send(av, bv, 0, 0, 0, 0, 0);
    send(av, bv, 0, 1, 0, 0, 0);
`ifdef SERIAL_MAC_SAT_EN
    chk("t5_g0_acc", acc_out1[31:0], 32'hFFFFFFFF);
`else
    chk("t5_g0_acc", acc_out1[31:0], 32'hFFFC0002);
`endif
    chk("t5_g0_ovf", overflow1, 2'b11);
    chk("t5_guard_acc", acc_out[39:0], 40'h01FFFC0002);
    drain();
    av = '0; bv = '0; av[15:0] = 11; bv[15:0] = 13;
    send(av, bv, 0, 0, 0, 0, 1);
    hold = 1;
    av[15:0] = 4; bv[15:0] = 4;
    send(av, bv, 0, 1, 0, 0, 0);
    chk("t6_after_abort", acc_out[39:0], 40'd16);
    repeat (5) @(negedge clk);
    chk("t6_held_valid", out_valid, 1);
    drain();
    for (int i = 0; i < 60; i++) begin
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      send(av, bv, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, 0);
    end
    av = '0; bv = '0;
    send(av, bv, 0, 1, 0, 0, 0);
    drain();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
